// File: rtl/neural_layer_stream_pkg.sv
// rtl/neural_layer_stream_pkg.sv - shared constants, FSM state type and single-precision float helpers
package neural_layer_stream_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int ACT_IDENTITY = 0;
  localparam int ACT_RELU     = 1;
  localparam int SIGN_BIT     = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Round-to-nearest-even multiply; denormal inputs and results flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [47:0]        p;
    logic [23:0]        m;
    logic               g;
    logic               st;
    logic [24:0]        mr;
    logic signed [10:0] e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) return FP_QNAN;
    if (ea == 8'hFF || eb == 8'hFF) return (ea == 8'd0 || eb == 8'd0) ? FP_QNAN : {s, 8'hFF, 23'd0};
    if (ea == 8'd0 || eb == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + 25'(g & (st | m[0]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 11'sd1;
    end
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // Round-to-nearest-even add; exact cancellation yields +0, denormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x;
    logic [31:0]        y;
    logic [49:0]        mx;
    logic [49:0]        my;
    logic [50:0]        sum;
    logic [50:0]        n;
    logic [7:0]         d;
    logic               lost;
    logic [24:0]        mr;
    logic signed [10:0] e;
    int                 lead;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return FP_QNAN;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] != b[31]) ? FP_QNAN : a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d    = x[30:23] - y[30:23];
    mx   = {1'b1, x[22:0], 26'd0};
    my   = {1'b1, y[22:0], 26'd0};
    lost = 1'b0;
    if (d >= 8'd50) begin
      lost = 1'b1;
      my   = '0;
    end else begin
      for (int i = 0; i < 50; i++) if (i < int'(d) && my[i]) lost = 1'b1;
      my = my >> d;
    end
    // Bits shifted out survive as a sticky LSB far below the rounding position.
    my[0] = my[0] | lost;
    sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    if (sum == 51'd0) return FP_ZERO;
    lead = 0;
    for (int i = 0; i < 51; i++) if (sum[i]) lead = i;
    n  = sum << (50 - lead);
    e  = $signed({3'b000, x[30:23]}) + 11'(lead) - 11'sd49;
    mr = {1'b0, n[50:27]} + 25'(n[26] & ((|n[25:0]) | n[27]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 11'sd1;
    end
    if (e >= 11'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 11'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_act(input logic [31:0] v, input int mode);
    return (mode != ACT_IDENTITY && v[SIGN_BIT]) ? FP_ZERO : v;
  endfunction

endpackage

// File: rtl/neural_mac_lane.sv
// rtl/neural_mac_lane.sv - one accumulator lane: rounded multiply followed by a separately rounded add
module neural_mac_lane
  import neural_layer_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        acc_en,
  input  logic [31:0] bias,
  input  logic [31:0] x,
  input  logic [31:0] w,
  output logic [31:0] acc
);

  logic [31:0] product;
  logic [31:0] sum;

  always_comb begin
    product = fp_mul(x, w);
    sum     = fp_add(acc, product);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= FP_ZERO;
    else if (load)   acc <= bias;
    else if (acc_en) acc <= sum;
  end

endmodule

// File: rtl/neural_layer_stream.sv
// rtl/neural_layer_stream.sv - handshaked fully-connected float layer evaluating LANES neurons per group
module neural_layer_stream
  import neural_layer_stream_pkg::*;
#(
  parameter int IN_SIZE    = 25,
  parameter int OUT_SIZE   = 20,
  parameter int LANES      = 4,
  parameter int ACTIVATION = ACT_RELU
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [32*IN_SIZE-1:0]           in,
  input  logic [32*IN_SIZE*OUT_SIZE-1:0]  weights,
  input  logic [32*OUT_SIZE-1:0]          bias,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [32*OUT_SIZE-1:0]          result,
  output logic                            busy
);

  localparam int GROUPS = (OUT_SIZE + LANES - 1) / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int KW     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [KW-1:0]          k_cnt;
  logic [GW-1:0]          g_cnt;
  logic [32*IN_SIZE-1:0]  in_reg;
  logic [32*OUT_SIZE-1:0] bias_reg;
  logic                   accept;
  logic                   last_k;
  logic                   last_g;
  logic                   lane_load_en;
  logic                   lane_mac_en;
  logic [31:0]            x_sel;
  logic [31:0]            lane_w   [LANES];
  logic [31:0]            lane_b   [LANES];
  logic [31:0]            lane_acc [LANES];
  logic [LANES-1:0]       lane_on;

  // Neuron index served by lane l in group g, clamped so unused lanes never select out of range.
  function automatic int neuron(input int g, input int l);
    return (g * LANES + l < OUT_SIZE) ? g * LANES + l : OUT_SIZE - 1;
  endfunction

  assign accept = in_valid && in_ready;
  assign last_k = (k_cnt == KW'(IN_SIZE - 1));
  assign last_g = (g_cnt == GW'(GROUPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_MAC;
      ST_MAC:   if (last_k) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_g ? ST_DONE : ST_LOAD;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == ST_IDLE);
    out_valid    = (state == ST_DONE);
    busy         = (state == ST_LOAD) || (state == ST_MAC) || (state == ST_WRITE);
    lane_load_en = (state == ST_LOAD);
    lane_mac_en  = (state == ST_MAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt    <= '0;
      g_cnt    <= '0;
      in_reg   <= '0;
      bias_reg <= '0;
    end else begin
      if (accept) begin
        in_reg   <= in;
        bias_reg <= bias;
        g_cnt    <= '0;
      end
      if (state == ST_LOAD)                k_cnt <= '0;
      else if (state == ST_MAC && !last_k) k_cnt <= k_cnt + 1'b1;
      if (state == ST_WRITE && !last_g)    g_cnt <= g_cnt + 1'b1;
    end
  end

  always_comb begin
    x_sel = '0;
    for (int k = 0; k < IN_SIZE; k++) if (k_cnt == KW'(k)) x_sel = in_reg[32*k +: 32];
  end

  // Weights are read live from the port; the caller holds them until the output handshake.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_on[l] = 1'b0;
      lane_b[l]  = '0;
      lane_w[l]  = '0;
      for (int g = 0; g < GROUPS; g++) begin
        if (g_cnt == GW'(g) && g * LANES + l < OUT_SIZE) begin
          lane_on[l] = 1'b1;
          lane_b[l]  = bias_reg[32*neuron(g, l) +: 32];
          for (int k = 0; k < IN_SIZE; k++)
            if (k_cnt == KW'(k)) lane_w[l] = weights[32*(neuron(g, l)*IN_SIZE + k) +: 32];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    neural_mac_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (lane_load_en && lane_on[l]),
      .acc_en (lane_mac_en && lane_on[l]),
      .bias   (lane_b[l]),
      .x      (x_sel),
      .w      (lane_w[l]),
      .acc    (lane_acc[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (state == ST_WRITE) begin
      for (int g = 0; g < GROUPS; g++)
        for (int l = 0; l < LANES; l++)
          if (g_cnt == GW'(g) && g * LANES + l < OUT_SIZE)
            result[32*neuron(g, l) +: 32] <= fp_act(lane_acc[l], ACTIVATION);
    end
  end

endmodule
